// File: rtl/sdram_req_queue.sv
// sdram_req_queue: in-order request FIFO plus a one-at-a-time issue sequencer
// sitting in front of the SDRAM controller host port. Each enable is held until
// the controller's busy shows acceptance. Reads return data as one-cycle
// response pulses, in request order.
// Optional feature: define SDRAM_REQ_TIMEOUT_EN to bound the wait for busy.
// On a timeout the request is dropped and timeout_err is set.
module sdram_req_queue #(
  parameter int          HADDR_WIDTH    = 24,
  parameter int          DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  // host request side
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [HADDR_WIDTH-1:0]   req_addr,
  input  logic [15:0]              req_wdata,
  // host response side
  output logic                     rsp_valid,
  output logic [15:0]              rsp_rdata,
  // controller side
  output logic [HADDR_WIDTH-1:0]   wr_addr,
  output logic [HADDR_WIDTH-1:0]   rd_addr,
  output logic [15:0]              wr_data,
  output logic                     wr_enable,
  output logic                     rd_enable,
  input  logic [15:0]              rd_data,
  input  logic                     rd_ready,
  input  logic                     busy,
  // status
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 1 + HADDR_WIDTH + 16;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_WR, S_WAIT_RD} state_t;

  state_t                 state;
  logic [EW-1:0]          mem [DEPTH];
  logic [PW-1:0]          wptr, rptr;
  logic [PW:0]            count;
  logic                   full, empty, push, pop;
  logic [EW-1:0]          head;
  logic                   head_write;
  logic [HADDR_WIDTH-1:0] head_addr;
  logic [15:0]            head_data;
  logic [HADDR_WIDTH-1:0] iss_addr;
  logic [15:0]            iss_data;

  // No bypass: a full FIFO refuses pushes even on the cycle it pops.
  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign req_ready = !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && !empty;
  assign pending   = count;

  assign head       = mem[rptr];
  assign head_write = head[EW-1];
  assign head_addr  = head[EW-2:16];
  assign head_data  = head[15:0];

  // Both controller address ports follow the single issue address register.
  assign wr_addr = iss_addr;
  assign rd_addr = iss_addr;
  assign wr_data = iss_data;

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {req_write, req_addr, req_wdata};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SDRAM_REQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            to_err;

  assign timeout_err = to_err;
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout_err        = 1'b0;
`endif

  // Issue sequencer: pop, hold the enable until busy is seen, then wait for
  // write completion (busy low) or read data (rd_ready).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_enable <= 1'b0;
      rd_enable <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      iss_addr  <= '0;
      iss_data  <= '0;
`ifdef SDRAM_REQ_TIMEOUT_EN
      to_cnt    <= '0;
      to_err    <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            iss_addr  <= head_addr;
            iss_data  <= head_data;
            wr_enable <= head_write;
            rd_enable <= !head_write;
`ifdef SDRAM_REQ_TIMEOUT_EN
            to_cnt    <= '0;
`endif
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // busy low here means init/refresh or the controller's one-cycle lag
          if (busy) begin
            wr_enable <= 1'b0;
            rd_enable <= 1'b0;
            state     <= wr_enable ? S_WAIT_WR : S_WAIT_RD;
          end
`ifdef SDRAM_REQ_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            // give up: drop the request silently, flag it stickily
            wr_enable <= 1'b0;
            rd_enable <= 1'b0;
            to_err    <= 1'b1;
            state     <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_WAIT_WR: begin
          if (!busy) state <= S_IDLE;
        end
        S_WAIT_RD: begin
          if (rd_ready) begin
            rsp_rdata <= rd_data;
            rsp_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_req_queue.sv
// Directed bench for sdram_req_queue with a small SDRAM controller model.
// The model raises busy two cycles after it first sees an enable (plus an
// optional refresh stall), holds busy for 6 cycles, and for reads pulses
// rd_ready with rd_data = addr[15:0] + 16'hBEDF as busy drops.
module tb_sdram_req_queue;
  localparam int AW    = 24;
  localparam int DEPTH = 4;
`ifdef SDRAM_REQ_TIMEOUT_EN
  localparam int STALL = 4;
`else
  localparam int STALL = 10;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [15:0]   req_wdata = '0;
  logic          rsp_valid;
  logic [15:0]   rsp_rdata;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [15:0]   wr_data;
  logic          wr_enable, rd_enable;
  logic [15:0]   rd_data;
  logic          rd_ready;
  logic          busy;
  logic [2:0]    pending;
  logic          timeout_err;

  sdram_req_queue #(.HADDR_WIDTH(AW), .DEPTH(DEPTH), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
    .wr_enable(wr_enable), .rd_enable(rd_enable),
    .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy),
    .pending(pending), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- controller model ----------------
  typedef enum int {M_IDLE, M_DLY, M_BUSY, M_STUCK} mst_t;
  mst_t          m_st;
  logic          m_rst_n = 1'b0;
  logic          m_rd;
  logic [AW-1:0] m_addr;
  int            m_cnt;
  int            stall = 0;
  bit            stuck = 1'b0;

  always @(posedge clk) begin
    if (!m_rst_n) begin
      m_st <= M_IDLE; busy <= 1'b0; rd_ready <= 1'b0; rd_data <= '0;
      m_rd <= 1'b0; m_addr <= '0; m_cnt <= 0;
    end else begin
      rd_ready <= 1'b0;
      case (m_st)
        M_IDLE: if (wr_enable || rd_enable) begin
          m_rd <= rd_enable; m_addr <= rd_addr; m_cnt <= stall;
          m_st <= stuck ? M_STUCK : M_DLY;
        end
        M_DLY: if (m_cnt == 0) begin
          busy <= 1'b1; m_cnt <= 5; m_st <= M_BUSY;
        end else m_cnt <= m_cnt - 1;
        M_BUSY: if (m_cnt == 0) begin
          busy <= 1'b0;
          if (m_rd) begin rd_ready <= 1'b1; rd_data <= m_addr[15:0] + 16'hBEDF; end
          m_st <= M_IDLE;
        end else m_cnt <= m_cnt - 1;
        M_STUCK: if (!wr_enable && !rd_enable) m_st <= M_IDLE;
        default: m_st <= M_IDLE;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic          iss_w [$];
  logic [AW-1:0] iss_a [$];
  logic [15:0]   iss_d [$];
  logic [15:0]   rsp_q [$];
  logic          en_prev = 1'b0, rsp_prev = 1'b0;
  logic [AW-1:0] a0 = '0;
  int            cur_len = 0, last_len = 0;
  int            addr_moves = 0, both_hi = 0, long_rsp = 0, ready_bad = 0;

  always @(negedge clk) begin
    if ((wr_enable || rd_enable) && !en_prev) begin
      iss_w.push_back(wr_enable); iss_a.push_back(wr_addr); iss_d.push_back(wr_data);
      cur_len = 0; a0 = wr_addr;
    end
    if (wr_enable || rd_enable) begin
      cur_len++;
      if (wr_addr != a0 || rd_addr != a0) addr_moves++;
    end
    if (!(wr_enable || rd_enable) && en_prev) last_len = cur_len;
    if (wr_enable && rd_enable) both_hi++;
    if (rsp_valid) begin
      rsp_q.push_back(rsp_rdata);
      if (rsp_prev) long_rsp++;
    end
    if (rst_n && (req_ready != (pending != 3'(DEPTH)))) ready_bad++;
    en_prev  = wr_enable || rd_enable;
    rsp_prev = rsp_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input logic w, input logic [AW-1:0] a, input logic [15:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("push_ready_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag);
    int q = 0;
    int n = 0;
    while (q < 3 && n < 500) begin
      @(negedge clk); n++;
      if (pending == 0 && !wr_enable && !rd_enable && !busy && m_st == M_IDLE) q++;
      else q = 0;
    end
    if (q < 3) chk(tag, 32'd1, 32'd0);
  endtask

  int b, r;

  initial begin
    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; m_rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_pending", pending, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_en", {wr_enable, rd_enable}, 0);
    chk("rst_rsp", {rsp_valid, rsp_rdata}, 0);
    chk("rst_addr_data", {wr_addr, wr_data}, 0);
    chk("rst_terr", timeout_err, 0);

    // ---- single write: enable high exactly 3 cycles ----
    b = iss_a.size();
    push(1'b1, 24'h012345, 16'hA5A5);
    chk("w_pending1", pending, 1);
    chk("w_en_not_yet", wr_enable, 0);
    @(posedge clk); #1;
    chk("w_en_on", {wr_enable, rd_enable}, 2'b10);
    chk("w_pending0", pending, 0);
    wait_quiet("w_quiet_timeout");
    chk("w_len", last_len, 3);
    chk("w_addr", iss_a[b], 24'h012345);
    chk("w_data", iss_d[b], 16'hA5A5);
    chk("w_wbit", iss_w[b], 1);
    chk("w_pending_end", pending, 0);

    // ---- single read: one pulse, data held ----
    b = iss_a.size(); r = rsp_q.size();
    push(1'b0, 24'h000010, 16'h0000);
    wait_quiet("r_quiet_timeout");
    chk("r_wbit", iss_w[b], 0);
    chk("r_rsp_count", rsp_q.size() - r, 1);
    chk("r_rsp_data", rsp_q[r], 16'hBEEF);
    chk("r_rsp_held", rsp_rdata, 16'hBEEF);
    chk("r_rsp_low", rsp_valid, 0);

    // ---- fill FIFO behind an in-flight write, then check order ----
    b = iss_a.size(); r = rsp_q.size();
    push(1'b1, 24'h000050, 16'h3333);
    push(1'b1, 24'h000100, 16'h1111);
    push(1'b0, 24'h000200, 16'h0000);
    push(1'b0, 24'h000300, 16'h0000);
    push(1'b1, 24'h000400, 16'h2222);
    chk("f_pending_full", pending, 4);
    chk("f_ready_full", req_ready, 0);
    begin
      int n = 0;
      while (pending == 4 && n < 100) begin @(negedge clk); n++; end
    end
    chk("f_pending_pop", pending, 3);
    chk("f_ready_pop", req_ready, 1);
    wait_quiet("f_quiet_timeout");
    chk("f_iss_count", iss_a.size() - b, 5);
    chk("f_wbits", {iss_w[b], iss_w[b+1], iss_w[b+2], iss_w[b+3], iss_w[b+4]}, 5'b11001);
    chk("f_a1", iss_a[b+1], 24'h000100);
    chk("f_a2", iss_a[b+2], 24'h000200);
    chk("f_a3", iss_a[b+3], 24'h000300);
    chk("f_a4", iss_a[b+4], 24'h000400);
    chk("f_d4", iss_d[b+4], 16'h2222);
    chk("f_rsp_count", rsp_q.size() - r, 2);
    chk("f_rsp0", rsp_q[r], 16'hC0DF);
    chk("f_rsp1", rsp_q[r+1], 16'hC1DF);

    // ---- refresh stall: enable held with stable address ----
    b = iss_a.size();
    stall = STALL;
    push(1'b1, 24'h000777, 16'h5A5A);
    wait_quiet("s_quiet_timeout");
    stall = 0;
    chk("s_len", last_len, 3 + STALL);
    chk("s_addr", iss_a[b], 24'h000777);
    chk("s_terr", timeout_err, 0);

`ifdef SDRAM_REQ_TIMEOUT_EN
    // ---- busy stuck low: timeout drops request, next entry issues ----
    b = iss_a.size(); r = rsp_q.size();
    stuck = 1'b1;
    push(1'b0, 24'h000600, 16'h0000);
    push(1'b1, 24'h000700, 16'h1234);
    begin
      int n = 0;
      while (m_st != M_STUCK && n < 50) begin @(negedge clk); n++; end
    end
    stuck = 1'b0;
    wait_quiet("t_quiet_timeout");
    chk("t_terr", timeout_err, 1);
    chk("t_iss_count", iss_a.size() - b, 2);
    chk("t_next_addr", iss_a[b+1], 24'h000700);
    chk("t_no_rsp", rsp_q.size() - r, 0);
    chk("t_len_write", last_len, 3);
`endif

    // ---- reset while waiting on read data, 2 entries queued ----
    b = iss_a.size(); r = rsp_q.size();
    push(1'b0, 24'h000800, 16'h0000);
    push(1'b1, 24'h000900, 16'h4444);
    push(1'b0, 24'h000A00, 16'h0000);
    begin
      int n = 0;
      while (!(busy && !rd_enable && m_st == M_BUSY) && n < 50) begin @(negedge clk); n++; end
    end
    chk("x_pending_before", pending, 2);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("x_en", {wr_enable, rd_enable}, 0);
    chk("x_pending", pending, 0);
    chk("x_ready", req_ready, 1);
    chk("x_rdata", rsp_rdata, 0);
    chk("x_terr", timeout_err, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("x_no_rsp", rsp_q.size() - r, 0);
    chk("x_no_issue", iss_a.size() - b, 1);

    // ---- global invariants ----
    chk("inv_both_hi", both_hi, 0);
    chk("inv_long_rsp", long_rsp, 0);
    chk("inv_ready", ready_bad, 0);
    chk("inv_addr_stable", addr_moves, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // safety net: never hang
  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "global timeout");
  end
endmodule
